branch_config_scheduler: RTL and testbench
==========================================

// Module: branch_config_scheduler
// PURPOSE
//  Schedules writes into the per-thread branch configuration memory of the branch detector.
//  That memory accepts a write for thread T only in the cycle its thread slot equals T.
//  Requesters (host/debug/threads) submit {thread, config word} at any time.
//  This block buffers one pending word per thread and drives the detector's write port in that thread's slot.
// PARAMETERS
//  WORD_WIDTH          36  width of configuration word forwarded to the detector
//  THREAD_COUNT        8   number of hardware threads / slots in the rotation
//  THREAD_COUNT_WIDTH  3   clog2(THREAD_COUNT)
//  INITIAL_THREAD      0   current_thread value after reset; must equal the detector's slot counter init
// PORTS
//  clock               in   1    sole clock
//  reset_n             in   1    asynchronous, active-low reset
//  req_valid           in   1    request present
//  req_ready           out  1    request accepted this cycle when req_valid & req_ready
//  req_thread          in   TCW  target thread of request
//  req_data            in   WW   configuration word
//  flush               in   1    synchronous: discard all pending words
//  configuration_wren  out  1    to detector write enable (registered)
//  configuration_data  out  WW   to detector write data (registered)
//  current_thread      out  TCW  slot whose write is presented this cycle
//  pending             out  TC   bit T set = word for thread T waiting
//  issued              out  1    pulse, coincident with configuration_wren
// BEHAVIOUR
//  - Reset (async assert, sync release): pending=0, storage don't-care.
//    Reset outputs: configuration_wren=0, configuration_data=0, issued=0, current_thread=INITIAL_THREAD.
//  - Slot counter: current_thread increments by 1 every cycle, wraps THREAD_COUNT-1 -> 0; never stalls.
//    next_thread = (current_thread+1) mod THREAD_COUNT.
//  - Accept: req_ready = !flush & !pending[req_thread]. Combinational from req_thread; no valid->ready dependency.
//    On accept at edge k, store req_data in entry req_thread and set its pending bit (visible cycle k+1).
//  - No overwrite: a request for a thread already pending stalls (ready=0) until that entry issues.
//  - Issue decision is made in cycle c on next_thread=N.
//    If pending[N] (as registered at start of c), at edge c+1:
//    configuration_wren=1, configuration_data=entry[N], issued=1, pending[N] cleared.
//    Otherwise wren=0, data=0, issued=0. So wren is high exactly in a cycle where current_thread==N.
//  - Latency: accept at edge k (thread tag T) -> wren high in first cycle m>=k+2 with current_thread==T.
//    Range 2..THREAD_COUNT+1 cycles.
//  - Same-edge accept and issue of one entry is impossible: ready=0 while pending.
//    Accept for thread N in the cycle N is being decided does not issue this rotation (pending not yet set).
//  - Simultaneous accept for thread A and issue for thread B (A!=B) both take effect.
//  - flush: clears all pending bits at next edge and suppresses the issue decided in that cycle (wren=0 next cycle).
//    An issue already registered (wren high during flush) still completes. req_ready=0 while flush.
//  - At most one write per cycle; every accepted, non-flushed word is written exactly once.
//  - Reset mid-operation: pending words lost, any in-flight wren drops immediately, counter returns to INITIAL_THREAD.
// STRUCTURE
//  - Storage: THREAD_COUNT x WORD_WIDTH register array (or MLAB), 1 write port (accept), 1 read port (next_thread).
//  - Sub-module thread_slot_counter: mod-THREAD_COUNT counter with async active-low reset;
//    outputs current_thread/next_thread. Replaces Thread_Number here because reset is required.
//  - Shared package/defines: OCTAVO_THREAD_COUNT, OCTAVO_THREAD_COUNT_WIDTH; branch config field widths (origin, enable,
//    destination, predict taken/enable, condition) so requesters pack words consistently.
// TESTING (THREAD_COUNT=8, INITIAL_THREAD=0)
//  1. Reset release: wren=0, data=0, pending=0, current_thread 0,1,...,7,0 on successive cycles.
//  2. Accept {T=5, 0xABC} while current_thread=1 -> pending=0x20.
//     wren=1, data=0xABC, issued=1 exactly in the cycle current_thread=5; pending back to 0.
//  3. Accept T=3 in cycle where current_thread=2 (next=3) -> no write this rotation; wren in next current_thread=3 (9 cycles later).
//  4. Second request T=5 while T=5 pending -> req_ready=0 until cycle after the issue, then accepted; both words written in order.
//  5. Load all 8 threads back-to-back -> exactly 8 wren pulses, one per slot, data matches thread tag; no loss or duplicates.
//  6. flush with pending=0xFF -> pending=0 next cycle, no further wren.
//     Separately: reset_n low with wren high -> wren=0 asynchronously, pending=0.

Source files
------------

// File: rtl/branch_config_scheduler_pkg.sv
// Shared thread-count constants and branch configuration word layout
// used by the scheduler and by every requester that packs config words.
package branch_config_scheduler_pkg;

  localparam int OCTAVO_THREAD_COUNT       = 8;
  localparam int OCTAVO_THREAD_COUNT_WIDTH = 3;

  localparam int BC_ORIGIN_WIDTH         = 10;
  localparam int BC_ORIGIN_ENABLE_WIDTH  = 1;
  localparam int BC_DESTINATION_WIDTH    = 10;
  localparam int BC_PREDICT_TAKEN_WIDTH  = 1;
  localparam int BC_PREDICT_ENABLE_WIDTH = 1;
  localparam int BC_CONDITION_WIDTH      = 13;

  localparam int BC_WORD_WIDTH =
    BC_ORIGIN_WIDTH + BC_ORIGIN_ENABLE_WIDTH +
    BC_DESTINATION_WIDTH + BC_PREDICT_TAKEN_WIDTH +
    BC_PREDICT_ENABLE_WIDTH + BC_CONDITION_WIDTH;

  typedef struct packed {
    logic [BC_ORIGIN_WIDTH-1:0]         origin;
    logic [BC_ORIGIN_ENABLE_WIDTH-1:0]  origin_enable;
    logic [BC_DESTINATION_WIDTH-1:0]    destination;
    logic [BC_PREDICT_TAKEN_WIDTH-1:0]  predict_taken;
    logic [BC_PREDICT_ENABLE_WIDTH-1:0] predict_enable;
    logic [BC_CONDITION_WIDTH-1:0]      condition;
  } branch_config_t;

  function automatic logic [BC_WORD_WIDTH-1:0] bc_pack(
    input branch_config_t cfg
  );
    return cfg;
  endfunction

endpackage

// File: rtl/branch_config_scheduler_thread_slot_counter.sv
// Free-running mod-THREAD_COUNT slot counter tracking the detector's
// thread rotation; must reset to the same value as the detector's counter.
module thread_slot_counter
  import branch_config_scheduler_pkg::*;
#(
  parameter int THREAD_COUNT       = OCTAVO_THREAD_COUNT,
  parameter int THREAD_COUNT_WIDTH = OCTAVO_THREAD_COUNT_WIDTH,
  parameter int INITIAL_THREAD     = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
  output logic [THREAD_COUNT_WIDTH-1:0] next_thread
);

  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST =
    THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] INIT =
    THREAD_COUNT_WIDTH'(INITIAL_THREAD);

  logic [THREAD_COUNT_WIDTH-1:0] thread_q;
  logic [THREAD_COUNT_WIDTH-1:0] thread_d;

  always_comb begin
    thread_d = thread_q + 1'b1;
    if (thread_q == LAST) begin
      thread_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thread_q <= INIT;
    end else begin
      thread_q <= thread_d;
    end
  end

  assign current_thread = thread_q;
  assign next_thread    = thread_d;

endmodule

// File: rtl/branch_config_scheduler.sv
// Buffers one pending config word per thread and writes it into the
// branch detector's config memory during that thread's slot.
module branch_config_scheduler
  import branch_config_scheduler_pkg::*;
#(
  parameter int WORD_WIDTH         = BC_WORD_WIDTH,
  parameter int THREAD_COUNT       = OCTAVO_THREAD_COUNT,
  parameter int THREAD_COUNT_WIDTH = OCTAVO_THREAD_COUNT_WIDTH,
  parameter int INITIAL_THREAD     = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [THREAD_COUNT_WIDTH-1:0] req_thread,
  input  logic [WORD_WIDTH-1:0]         req_data,
  input  logic                          flush,
  output logic                          configuration_wren,
  output logic [WORD_WIDTH-1:0]         configuration_data,
  output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
  output logic [THREAD_COUNT-1:0]       pending,
  output logic                          issued
);

  logic [THREAD_COUNT_WIDTH-1:0] next_thread;

  logic [THREAD_COUNT-1:0] pending_q;
  logic [THREAD_COUNT-1:0] pending_d;
  logic [WORD_WIDTH-1:0]   entry_q [THREAD_COUNT];
  logic                    wren_q;
  logic                    wren_d;
  logic [WORD_WIDTH-1:0]   data_q;
  logic [WORD_WIDTH-1:0]   data_d;

  logic accept;
  logic issue;

  thread_slot_counter #(
    .THREAD_COUNT       (THREAD_COUNT),
    .THREAD_COUNT_WIDTH (THREAD_COUNT_WIDTH),
    .INITIAL_THREAD     (INITIAL_THREAD)
  ) u_slot (
    .clock          (clock),
    .reset_n        (reset_n),
    .current_thread (current_thread),
    .next_thread    (next_thread)
  );

  // A pending entry is never overwritten: its requester stalls until issue.
  assign req_ready = !flush && !pending_q[req_thread];
  assign accept    = req_valid && req_ready;
  assign issue     = pending_q[next_thread] && !flush;

  always_comb begin
    pending_d = pending_q;
    if (accept) begin
      pending_d[req_thread] = 1'b1;
    end
    if (issue) begin
      pending_d[next_thread] = 1'b0;
    end
    if (flush) begin
      pending_d = '0;
    end
  end

  always_comb begin
    wren_d = issue;
    data_d = '0;
    if (issue) begin
      data_d = entry_q[next_thread];
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      entry_q[req_thread] <= req_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      wren_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      wren_q    <= wren_d;
      data_q    <= data_d;
    end
  end

  assign configuration_wren = wren_q;
  assign configuration_data = data_q;
  assign issued             = wren_q;
  assign pending            = pending_q;

endmodule

// File: tb/tb_branch_config_scheduler.sv
// Randomized scoreboard bench for branch_config_scheduler.
module tb_branch_config_scheduler;
  import branch_config_scheduler_pkg::*;

  localparam int WW   = 36;
  localparam int TC   = 8;
  localparam int TCW  = 3;
  localparam int INIT = 0;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [TCW-1:0] req_thread = '0;
  logic [WW-1:0]  req_data = '0;
  logic           flush = 1'b0;
  logic           configuration_wren;
  logic [WW-1:0]  configuration_data;
  logic [TCW-1:0] current_thread;
  logic [TC-1:0]  pending;
  logic           issued;

  branch_config_scheduler #(
    .WORD_WIDTH         (WW),
    .THREAD_COUNT       (TC),
    .THREAD_COUNT_WIDTH (TCW),
    .INITIAL_THREAD     (INIT)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_thread         (req_thread),
    .req_data           (req_data),
    .flush              (flush),
    .configuration_wren (configuration_wren),
    .configuration_data (configuration_data),
    .current_thread     (current_thread),
    .pending            (pending),
    .issued             (issued)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            thread;
    logic [WW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Write cycle: first cycle m >= accept_cycle+2 whose slot is t.
  function automatic int due_of(input int t, input int c);
    int m;
    m = c + 2;
    while (((INIT + m) % TC) != t) m++;
    return m;
  endfunction

  function automatic logic [TC-1:0] model_pending(input int x);
    logic [TC-1:0] p;
    p = '0;
    foreach (sb[i]) if (sb[i].due > x) p[sb[i].thread] = 1'b1;
    return p;
  endfunction

  // Scoreboard push: record every request the model says is accepted.
  always @(posedge clock) begin
    logic [TC-1:0] pm;
    if (!reset_n) begin
      sb.delete();
      cyc = 0;
    end else begin
      pm = model_pending(cyc);
      if (flush) begin
        sb.delete();
      end else if (req_valid && !pm[req_thread]) begin
        sb.push_back('{int'(req_thread), req_data,
                       due_of(int'(req_thread), cyc)});
      end
      cyc++;
    end
  end

  // Monitor: compare DUT outputs against the model every cycle.
  always @(negedge clock) begin
    int            idx;
    logic [TC-1:0] p;
    logic          rdy;
    if (reset_n && mon_en) begin
      idx = -1;
      foreach (sb[i]) if (sb[i].due == cyc) idx = i;
      check("slot", 64'(current_thread), 64'((INIT + cyc) % TC));
      p = model_pending(cyc);
      check("pending", 64'(pending), 64'(p));
      rdy = !flush && !p[req_thread];
      check("req_ready", 64'(req_ready), 64'(rdy));
      if (idx >= 0) begin
        check("wren", 64'(configuration_wren), 64'd1);
        check("issued", 64'(issued), 64'd1);
        check("data", 64'(configuration_data), 64'(sb[idx].data));
        check("wr_thread", 64'(current_thread), 64'(sb[idx].thread));
        sb.delete(idx);
      end else begin
        check("wren_idle", 64'(configuration_wren), 64'd0);
        check("issued_idle", 64'(issued), 64'd0);
        check("data_idle", 64'(configuration_data), 64'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_slot(input int s);
    for (int n = 0; n < 2 * TC; n++) begin
      if (int'(current_thread) == s) break;
      step(1);
    end
  endtask

  task automatic send(input int t, input logic [WW-1:0] d);
    logic ok;
    ok = 1'b0;
    req_valid  = 1'b1;
    req_thread = TCW'(t);
    req_data   = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      ok = req_ready;
      @(posedge clock);
      #1;
      if (ok) break;
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: thread %0d never accepted", t);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 3 * TC && sb.size() != 0; n++) step(1);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [WW-1:0] rnd_word();
    return {4'($urandom()), $urandom()};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    #1;
    check("rst_wren", 64'(configuration_wren), 64'd0);
    check("rst_data", 64'(configuration_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_slot", 64'(current_thread), 64'(INIT));
    step(10);

    wait_slot(1);
    send(5, 36'hABC);
    step(10);

    wait_slot(2);
    send(3, 36'h333);
    step(12);

    wait_slot(0);
    send(5, 36'h5A);
    send(5, 36'h5B);
    step(12);

    wait_slot(0);
    for (int t = 0; t < TC; t++) send(t, rnd_word());
    drain();

    for (int n = 0; n < 300; n++) begin
      req_valid  = 1'($urandom());
      req_thread = TCW'($urandom());
      req_data   = rnd_word();
      flush      = ($urandom() % 40) == 0;
      step(1);
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    drain();

    // Fill every slot so that none issues before the flush lands.
    wait_slot(0);
    for (int i = 0; i < TC; i++) send((i + 1) % TC, rnd_word());
    check("full_pending", 64'(pending), 64'hFF);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flushed_pending", 64'(pending), 64'd0);
    step(12);

    send(4, 36'h4_DEAD_BEEF);
    got = 1'b0;
    for (int n = 0; n < 3 * TC; n++) begin
      @(negedge clock);
      if (configuration_wren) begin
        got = 1'b1;
        break;
      end
    end
    check("wren_seen", 64'(got), 64'd1);
    send(6, 36'h6);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_wren", 64'(configuration_wren), 64'd0);
    check("arst_data", 64'(configuration_data), 64'd0);
    check("arst_issued", 64'(issued), 64'd0);
    check("arst_pending", 64'(pending), 64'd0);
    check("arst_slot", 64'(current_thread), 64'(INIT));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1);
    send(2, 36'h22);
    drain();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
